// File: rtl/mod5_serial_scheduler.sv
// Two-requester round-robin front end for an LSB-first serial mod-5 residue engine.
// A granted word is shifted out one bit per clock while the residue accumulates.
module mod5_serial_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             bit_out,
  output logic             bit_valid,
  output logic [2:0]       residue,
  output logic             done,
  output logic             done_id
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic             last;
  logic             id;
  logic [WIDTH-1:0] sreg;
  logic [5:0]       count;
  logic [2:0]       weight;
  logic             accept;
  logic             pick1;
  logic             last_shift;
  logic [2:0]       res_add;
  logic [2:0]       w_dbl;

  // On a tie the requester that did not finish last wins.
  assign pick1      = req1 & (~req0 | ~last);
  assign accept     = (state == IDLE) & (req0 | req1);
  assign last_shift = (count == 6'(WIDTH - 1));

  // Modular add/double kept within 3 bits: subtract 5 only when the sum would reach 5.
  always_comb begin
    res_add = residue + weight;
    if (residue >= (3'd5 - weight))
      res_add = residue - (3'd5 - weight);
    w_dbl = {weight[1:0], 1'b0};
    if (weight >= 3'd3)
      w_dbl = {weight[1:0], 1'b0} - 3'd5;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      last    <= 1'b1;
      id      <= 1'b0;
      sreg    <= '0;
      count   <= '0;
      weight  <= 3'd1;
      residue <= '0;
      done_id <= 1'b0;
    end else begin
      gnt0 <= accept & ~pick1;
      gnt1 <= accept & pick1;
      case (state)
        IDLE: begin
          if (accept) begin
            sreg    <= pick1 ? data1 : data0;
            id      <= pick1;
            residue <= '0;
            weight  <= 3'd1;
            count   <= '0;
          end
        end
        SHIFT: begin
          if (sreg[0]) residue <= res_add;
          weight <= w_dbl;
          sreg   <= sreg >> 1;
          count  <= count + 6'd1;
          if (last_shift) done_id <= id;
        end
        DONE:    last <= id;
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign bit_valid = (state == SHIFT);
  assign done      = (state == DONE);
  assign bit_out   = sreg[0];

endmodule

// File: tb/tb_mod5_serial_scheduler.sv
// Self-checking bench: directed scenarios plus random jobs against a word-level
// model (residue = word % 5, round-robin winner from the previous completer).
module tb_mod5_serial_scheduler;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] data0 = '0, data1 = '0;
  logic         gnt0, gnt1, busy, bit_out, bit_valid, done, done_id;
  logic [2:0]   residue;

  int unsigned  chk_cnt = 0;
  int unsigned  pass_cnt = 0;
  logic         last_m = 1'b1;
  logic [2:0]   res_m = '0;
  time          t_accept = 0;
  time          t_prev = 0;

  mod5_serial_scheduler #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .bit_out(bit_out),
    .bit_valid(bit_valid), .residue(residue), .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else pass_cnt++;
  endtask

  task automatic do_reset(input int unsigned cycles);
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_gnt", {gnt0, gnt1}, 0);
    check("rst_done", {done, done_id}, 0);
    check("rst_residue", residue, 0);
    check("rst_bit", {bit_out, bit_valid}, 0);
    reset = 1'b0;
    last_m = 1'b1;
    res_m = '0;
  endtask

  // One complete job from the current req/data levels; tog wiggles the idle requester.
  task automatic job(input bit tog);
    logic         w;
    logic [W-1:0] word;
    logic         other0;
    longint       part;
    w    = (req0 && req1) ? ~last_m : req1;
    word = w ? data1 : data0;
    other0 = w ? req0 : req1;
    @(posedge clk); #1;
    t_prev = t_accept;
    t_accept = $time;
    check("gnt0", gnt0, (w == 1'b0));
    check("gnt1", gnt1, (w == 1'b1));
    check("busy_e0", busy, 1);
    check("valid_e0", bit_valid, 1);
    check("bit0", bit_out, word[0]);
    check("res_e0", residue, 0);
    if (w) req1 = 1'b0; else req0 = 1'b0;
    for (int k = 1; k <= W; k++) begin
      if (w) data1 = W'($urandom); else data0 = W'($urandom);
      if (tog) begin
        if (w) req0 = ~req0; else req1 = ~req1;
      end
      @(posedge clk); #1;
      part = longint'(word) % (longint'(1) << k);
      if (k < W) begin
        check("gnt_low", {gnt0, gnt1}, 0);
        check("valid", bit_valid, 1);
        check("bit", bit_out, word[k]);
        check("res_run", residue, 32'(part % 5));
        check("done_early", done, 0);
      end
    end
    if (tog) begin
      if (w) req0 = other0; else req1 = other0;
    end
    res_m = 3'(word % 5);
    check("done", done, 1);
    check("done_id", done_id, w);
    check("residue", residue, res_m);
    check("valid_off", bit_valid, 0);
    check("busy_done", busy, 1);
    last_m = w;
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    check("busy_off", busy, 0);
    check("id_hold", done_id, w);
    check("res_hold", residue, res_m);
  endtask

  initial begin
    do_reset(2);

    data0 = 8'd27; req0 = 1'b1; job(0);
    check("first_res", res_m, 2);

    data1 = 8'd31;  req1 = 1'b1; job(0);
    data1 = 8'd254; req1 = 1'b1; job(0);
    data1 = 8'd0;   req1 = 1'b1; job(0);

    repeat (4) @(posedge clk);
    #1;
    check("idle_res_hold", residue, res_m);
    check("idle_id_hold", done_id, 1);

    // tie straight after reset: requester 0 first, requester 1 at the next IDLE edge
    do_reset(2);
    data0 = 8'd10; data1 = 8'd218; req0 = 1'b1; req1 = 1'b1;
    job(0);
    check("tie_id0", done_id, 0);
    job(0);
    check("tie_res1", res_m, 3);
    check("spacing", 32'(t_accept - t_prev), (W + 2) * 10);

    // round robin after a requester-1 job, then after a requester-0 job
    data0 = W'($urandom); data1 = W'($urandom); req0 = 1'b1; req1 = 1'b1;
    job(0);
    check("rr_after1", done_id, 0);
    data0 = W'($urandom); req0 = 1'b1;
    job(0);
    check("rr_after0", done_id, 1);
    job(0);

    // reset during the fourth SHIFT cycle aborts the job
    data0 = 8'hA5; req0 = 1'b1;
    @(posedge clk); #1;
    check("abort_gnt", gnt0, 1);
    req0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_valid", bit_valid, 0);
    check("abort_res", residue, 0);
    check("abort_done", done, 0);
    reset = 1'b0;
    last_m = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      check("abort_nodone", {done, gnt0, gnt1}, 0);
    end
    data0 = 8'd77; req0 = 1'b1; job(0);

    // data and req1 noise during SHIFT
    data0 = 8'd199; req0 = 1'b1; job(1);
    check("noise_id", done_id, 0);

    for (int n = 0; n < 40; n++) begin
      data0 = W'($urandom); data1 = W'($urandom);
      case ($urandom_range(0, 2))
        0: req0 = 1'b1;
        1: req1 = 1'b1;
        default: begin req0 = 1'b1; req1 = 1'b1; end
      endcase
      job(0);
      if (req0 || req1) job(0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
